// File: rtl/tlp_arbiter.sv
// -----------------------------------------------------------------------------
// tlp_arbiter
//
// Packet-atomic round-robin arbiter merging PORTS upstream TLP streams onto a
// single TLP link (header/payload with sop/eop/valid/ready). A grant is taken
// in IDLE and held from the sop beat through the eop beat, so TLPs from
// different requesters are never interleaved. One bubble cycle separates
// consecutive packets.
//
// Optional build macro:
//   TLP_ARB_PRIO0_EN  port 0 gets strict priority at every arbitration; the
//                     round-robin pointer then rotates over ports 1..PORTS-1
//                     only. Packets in progress are never preempted.
//
// Ports:
//   clk        clock
//   rst        asynchronous reset, active-high
//   in_data    PORTS*PAYLOAD_SIZE payload, port i at [i*PAYLOAD_SIZE +: PAYLOAD_SIZE]
//   in_hdr     PORTS*HEADER_SIZE header, sliced the same way
//   in_sop     per-port start of packet
//   in_eop     per-port end of packet
//   in_valid   per-port beat valid
//   in_ready   per-port beat accepted (only the granted port can see ready)
//   out_data   merged payload
//   out_hdr    merged header
//   out_sop    merged start of packet
//   out_eop    merged end of packet
//   out_valid  merged beat valid
//   out_ready  downstream ready
//   enable     arbitration enable, only looked at when a new grant is issued
//   grant      one-hot current owner, zero when idle
//   busy       high while a packet is being transferred
//   sop_err    one-cycle pulse, the cycle after a beat with a misplaced sop
// -----------------------------------------------------------------------------
module tlp_arbiter #(
  parameter int PORTS        = 2,
  parameter int DOUBLE_WORD  = 32,
  parameter int HEADER_SIZE  = 4 * DOUBLE_WORD,
  parameter int PAYLOAD_SIZE = 8 * DOUBLE_WORD
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [PORTS*PAYLOAD_SIZE-1:0]   in_data,
  input  logic [PORTS*HEADER_SIZE-1:0]    in_hdr,
  input  logic [PORTS-1:0]                in_sop,
  input  logic [PORTS-1:0]                in_eop,
  input  logic [PORTS-1:0]                in_valid,
  output logic [PORTS-1:0]                in_ready,
  output logic [PAYLOAD_SIZE-1:0]         out_data,
  output logic [HEADER_SIZE-1:0]          out_hdr,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic                            out_valid,
  input  logic                            out_ready,
  input  logic                            enable,
  output logic [PORTS-1:0]                grant,
  output logic                            busy,
  output logic                            sop_err
);

  localparam int IDX_W = $clog2(PORTS);

`ifdef TLP_ARB_PRIO0_EN
  localparam bit PRIO0 = 1'b1;
`else
  localparam bit PRIO0 = 1'b0;
`endif

  typedef enum logic {IDLE, XFER} state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] owner, owner_next;
  logic [IDX_W-1:0] ptr, ptr_next;
  logic             first_beat, first_beat_next;
  logic             sop_err_next;
  logic [IDX_W-1:0] winner;
  logic             winner_found;
  logic             fire;

  // Per-port views of the flattened data/header buses.
  logic [PAYLOAD_SIZE-1:0] data_arr [PORTS];
  logic [HEADER_SIZE-1:0]  hdr_arr  [PORTS];

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      data_arr[i] = in_data[i*PAYLOAD_SIZE +: PAYLOAD_SIZE];
      hdr_arr[i]  = in_hdr[i*HEADER_SIZE +: HEADER_SIZE];
    end
  end

  // Winner search: first valid port at or above the pointer, wrapping. In
  // priority mode port 0 pre-empts the search and is skipped by the rotation.
  always_comb begin
    int               idx;
    logic [IDX_W-1:0] idx_sel;
    winner       = '0;
    winner_found = 1'b0;
    if (PRIO0 && in_valid[0]) begin
      winner_found = 1'b1;
    end
    for (int k = 0; k < PORTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      idx_sel = IDX_W'(idx);
      if (!winner_found && !(PRIO0 && idx == 0) && in_valid[idx_sel]) begin
        winner       = idx_sel;
        winner_found = 1'b1;
      end
    end
  end

  // Datapath: outputs follow the owner's inputs only while transferring.
  always_comb begin
    out_data  = '0;
    out_hdr   = '0;
    out_sop   = 1'b0;
    out_eop   = 1'b0;
    out_valid = 1'b0;
    in_ready  = '0;
    grant     = '0;
    fire      = 1'b0;
    if (state == XFER) begin
      out_data        = data_arr[owner];
      out_hdr         = hdr_arr[owner];
      out_sop         = in_sop[owner];
      out_eop         = in_eop[owner];
      out_valid       = in_valid[owner];
      in_ready[owner] = out_ready;
      grant[owner]    = 1'b1;
      fire            = in_valid[owner] && out_ready;
    end
  end

  assign busy = (state == XFER);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case leaves one unassigned and a latch is never inferred.
    state_next      = state;
    owner_next      = owner;
    ptr_next        = ptr;
    first_beat_next = first_beat;
    sop_err_next    = 1'b0;
    case (state)
      IDLE: begin
        if (enable && winner_found) begin
          state_next      = XFER;
          owner_next      = winner;
          first_beat_next = 1'b1;
        end
      end
      XFER: begin
        if (fire) begin
          first_beat_next = 1'b0;
          // sop must appear on the first beat of a grant and nowhere else.
          sop_err_next    = first_beat ? !out_sop : out_sop;
          if (out_eop) begin
            state_next = IDLE;
            if (owner == IDX_W'(PORTS - 1)) begin
              ptr_next = PRIO0 ? IDX_W'(1) : '0;
            end else if (!(PRIO0 && owner == '0)) begin
              ptr_next = owner + IDX_W'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= '0;
      ptr        <= '0;
      first_beat <= 1'b0;
      sop_err    <= 1'b0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      ptr        <= ptr_next;
      first_beat <= first_beat_next;
      sop_err    <= sop_err_next;
    end
  end

endmodule

// File: tb/tb_tlp_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tlp_arbiter
//
// Randomized bench for tlp_arbiter (3 ports). Each port runs a packet source
// with random lengths, occasional sop placement errors and stalls. A
// reference model tracks ownership, the rotation pointer and sop checking at
// packet level and predicts every output each cycle. Directed phases cover
// reset (initial and mid-packet), full contention, enable held low and
// heavy backpressure. Build with +define+TLP_ARB_PRIO0_EN for the priority
// variant; the model follows the same macro.
// -----------------------------------------------------------------------------
module tb_tlp_arbiter;

  localparam int PORTS = 3;
  localparam int DW    = 32;
  localparam int HS    = 4 * DW;
  localparam int PS    = 8 * DW;

  logic                  clk;
  logic                  rst;
  logic [PORTS*PS-1:0]   in_data;
  logic [PORTS*HS-1:0]   in_hdr;
  logic [PORTS-1:0]      in_sop;
  logic [PORTS-1:0]      in_eop;
  logic [PORTS-1:0]      in_valid;
  logic [PORTS-1:0]      in_ready;
  logic [PS-1:0]         out_data;
  logic [HS-1:0]         out_hdr;
  logic                  out_sop;
  logic                  out_eop;
  logic                  out_valid;
  logic                  out_ready;
  logic                  enable;
  logic [PORTS-1:0]      grant;
  logic                  busy;
  logic                  sop_err;

  tlp_arbiter #(
    .PORTS        (PORTS),
    .DOUBLE_WORD  (DW),
    .HEADER_SIZE  (HS),
    .PAYLOAD_SIZE (PS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_hdr    (in_hdr),
    .in_sop    (in_sop),
    .in_eop    (in_eop),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_hdr   (out_hdr),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .enable    (enable),
    .grant     (grant),
    .busy      (busy),
    .sop_err   (sop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- packet sources ----------------
  bit act   [PORTS];   // presenting a packet
  int len   [PORTS];   // beats in current packet
  int beat  [PORTS];   // index of beat on the wire
  int pid   [PORTS];   // packet counter
  int ekind [PORTS];   // 0 clean, 1 missing first sop, 2 extra sop on beat 1

  int rdy_pct, start_pct, en_pct;

  function automatic logic [31:0] word_of(int p);
    return (32'(p) << 24) | ((32'(pid[p]) & 32'hFFFF) << 8) | (32'(beat[p]) & 32'hFF);
  endfunction

  function automatic logic [PS-1:0] p_data(int p);
    return {8{word_of(p)}};
  endfunction

  function automatic logic [HS-1:0] p_hdr(int p);
    return {4{word_of(p) ^ 32'h000A_5A00}};
  endfunction

  function automatic bit p_sop(int p);
    bit s;
    s = (beat[p] == 0);
    if (ekind[p] == 1 && beat[p] == 0) s = 1'b0;
    if (ekind[p] == 2 && beat[p] == 1) s = 1'b1;
    return s;
  endfunction

  function automatic bit p_eop(int p);
    return beat[p] == len[p] - 1;
  endfunction

  task automatic apply_inputs();
    for (int p = 0; p < PORTS; p++) begin
      in_valid[p]            = act[p];
      in_sop[p]              = p_sop(p);
      in_eop[p]              = p_eop(p);
      in_data[p*PS +: PS]    = p_data(p);
      in_hdr[p*HS +: HS]     = p_hdr(p);
    end
  endtask

  task automatic randomize_inputs();
    out_ready = ($urandom_range(99) < rdy_pct);
    enable    = ($urandom_range(99) < en_pct);
    for (int p = 0; p < PORTS; p++) begin
      if (!act[p] && $urandom_range(99) < start_pct) begin
        act[p]   = 1'b1;
        len[p]   = $urandom_range(1, 4);
        beat[p]  = 0;
        ekind[p] = 0;
        if ($urandom_range(11) == 0) ekind[p] = 1;
        else if (len[p] >= 2 && $urandom_range(11) == 0) ekind[p] = 2;
      end
    end
    apply_inputs();
  endtask

  // ---------------- reference model ----------------
  bit m_busy;
  int m_owner;
  int m_ptr;
  bit m_first;
  bit m_err;

  function automatic int pick();
`ifdef TLP_ARB_PRIO0_EN
    if (act[0]) return 0;
`endif
    for (int k = 0; k < PORTS; k++) begin
      int idx;
      idx = (m_ptr + k) % PORTS;
`ifdef TLP_ARB_PRIO0_EN
      if (idx == 0) continue;
`endif
      if (act[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int next_ptr(int done_port);
`ifdef TLP_ARB_PRIO0_EN
    if (done_port == 0) return m_ptr;
    return (done_port + 1 < PORTS) ? done_port + 1 : 1;
`else
    return (done_port + 1) % PORTS;
`endif
  endfunction

  task automatic model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_first = 1'b0;
    m_err   = 1'b0;
  endtask

  // One clock: compare at negedge, then advance model and sources after posedge.
  task automatic step();
    logic [PORTS-1:0] eg;
    logic [PORTS-1:0] er;
    bit ev, fire, w_sop, w_eop;
    int w;
    @(negedge clk);
    eg = '0;
    er = '0;
    ev = 1'b0;
    if (m_busy) begin
      eg = PORTS'(1) << m_owner;
      ev = act[m_owner];
      er = out_ready ? eg : '0;
    end
    check("grant", grant, eg);
    check("busy", busy, m_busy);
    check("out_valid", out_valid, ev);
    check("in_ready", in_ready, er);
    check("sop_err", sop_err, m_err);
    if (ev) begin
      check("out_data", out_data, p_data(m_owner));
      check("out_hdr", out_hdr, p_hdr(m_owner));
      check("out_sop", out_sop, p_sop(m_owner));
      check("out_eop", out_eop, p_eop(m_owner));
    end
    fire = ev && out_ready;
    @(posedge clk);
    #1;
    m_err = 1'b0;
    if (m_busy) begin
      if (fire) begin
        w_sop   = p_sop(m_owner);
        w_eop   = p_eop(m_owner);
        m_err   = (m_first != w_sop);
        m_first = 1'b0;
        if (w_eop) begin
          act[m_owner] = 1'b0;
          pid[m_owner]++;
          m_busy = 1'b0;
          m_ptr  = next_ptr(m_owner);
        end else begin
          beat[m_owner]++;
        end
      end
    end else if (enable) begin
      w = pick();
      if (w >= 0) begin
        m_busy  = 1'b1;
        m_owner = w;
        m_first = 1'b1;
      end
    end
    randomize_inputs();
  endtask

  task automatic run_phase(input int rdy, input int start, input int en, input int cycles);
    rdy_pct   = rdy;
    start_pct = start;
    en_pct    = en;
    for (int c = 0; c < cycles; c++) step();
  endtask

  initial begin
    bit found;
    for (int p = 0; p < PORTS; p++) begin
      act[p]   = 1'b1;
      len[p]   = 2;
      beat[p]  = 0;
      pid[p]   = 0;
      ekind[p] = 0;
    end
    rst       = 1'b1;
    enable    = 1'b1;
    out_ready = 1'b1;
    apply_inputs();
    model_reset();

    // Reset holds everything quiet even with requests and enable present.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_hdr", out_hdr, '0);
    check("rst_out_sop_eop", {out_sop, out_eop}, 2'b00);
    check("rst_sop_err", sop_err, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Full contention from pointer 0, then mixed traffic.
    run_phase(100, 100, 100, 200);
    run_phase(50, 60, 100, 600);
    run_phase(30, 30, 90, 600);
    // Enable held low: current packet drains, no new grant.
    run_phase(80, 80, 0, 40);
    run_phase(70, 50, 70, 400);

    // Reset in the middle of a multi-beat packet.
    found = 1'b0;
    rdy_pct   = 50;
    start_pct = 80;
    en_pct    = 100;
    for (int c = 0; c < 300 && !found; c++) begin
      step();
      if (m_busy && beat[m_owner] > 0) found = 1'b1;
    end
    check("midpkt_found", found, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_grant", grant, '0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_in_ready", in_ready, '0);
    for (int p = 0; p < PORTS; p++) begin
      if (act[p]) pid[p]++;
      act[p]  = 1'b0;
      beat[p] = 0;
    end
    apply_inputs();
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // After reset the pointer is back at 0: all ports request at once.
    for (int p = 0; p < PORTS; p++) begin
      act[p]   = 1'b1;
      len[p]   = 2;
      beat[p]  = 0;
      ekind[p] = 0;
    end
    out_ready = 1'b1;
    enable    = 1'b1;
    apply_inputs();
    run_phase(100, 100, 100, 60);
    run_phase(60, 40, 95, 500);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/tlp_arbiter.md
Name: tlp_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges PORTS upstream TLP streams onto one TLP link.
- The TLP link uses header/payload with sop/eop/valid/ready signalling.
- Sits in front of tlp_demux and shares its single TLP input between requesters, e.g. the completion generator and the request generator.
- A grant is held from the sop beat to the eop beat, so TLPs are never interleaved.

Parameters:
- PORTS, 2: number of requesters; must be >= 2.
- DOUBLE_WORD, 32: DW width in bits.
- HEADER_SIZE, 4*DOUBLE_WORD: TLP header width.
- PAYLOAD_SIZE, 8*DOUBLE_WORD: payload beat width.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  PORTS*PAYLOAD_SIZE  payload per port; port i occupies slice [i*PAYLOAD_SIZE +: PAYLOAD_SIZE].
- in_hdr  input  PORTS*HEADER_SIZE  header per port, sliced the same way.
- in_sop  input  PORTS  start of packet, per port.
- in_eop  input  PORTS  end of packet, per port.
- in_valid  input  PORTS  beat valid, per port.
- in_ready  output  PORTS  beat accepted, per port.
- out_data  output  PAYLOAD_SIZE  merged payload.
- out_hdr  output  HEADER_SIZE  merged header.
- out_sop  output  1  merged start of packet.
- out_eop  output  1  merged end of packet.
- out_valid  output  1  merged beat valid.
- out_ready  input  1  downstream ready.
- enable  input  1  arbitration enable; sampled only at packet boundaries.
- grant  output  PORTS  one-hot current owner; zero when idle.
- busy  output  1  high while in XFER.
- sop_err  output  1  one-cycle pulse on a protocol violation.

Behaviour:
- Reset (rst high, asynchronous):
  - state = IDLE, grant = 0, round-robin pointer = 0, sop_err = 0.
  - All out_* = 0 and in_ready = 0 while in reset.
  - Reset mid-packet abandons the packet; no eop is emitted.
- State IDLE:
  - busy = 0, out_valid = 0, in_ready = 0.
  - If enable = 1 and |in_valid, select the winner: the first port with in_valid set, searching from pointer upward and wrapping modulo PORTS.
  - Register the winner into grant (one-hot) and go to XFER.
  - Arbitration latency: 1 cycle from valid to out_valid.
- State XFER:
  - busy = 1.
  - out_* is combinationally the granted port's in_* slice.
  - in_ready[g] = out_ready; in_ready of all other ports = 0.
  - A beat transfers when out_valid && out_ready.
  - On a transfer with out_eop = 1: pointer = (g+1) mod PORTS, grant = 0, go to IDLE. There is one bubble cycle between packets.
- Protocol check: the first transferred beat after a grant must have sop = 1.
  - If it does not, sop_err pulses for 1 cycle and the beat is still forwarded.
  - A beat with sop = 1 after the first beat of a packet also pulses sop_err.
- Single-beat packet (sop = eop = 1): transfers in one cycle, then IDLE.
- enable deasserted in XFER: the current packet completes; no new grant is issued until enable = 1.
- Non-granted requesters holding valid are stalled (ready = 0) and keep their beat stable.
- Upstream rule: valid must not drop mid-packet before its beat transfers. Outputs still track the inputs combinationally if it does.
- Fairness: with all ports continuously requesting, grants rotate 0, 1, ..., PORTS-1, 0, ...

Optional Feature:
- Macro: TLP_ARB_PRIO0_EN.
- Defined: port 0 has strict priority.
  - In IDLE, in_valid[0] = 1 always wins.
  - Otherwise round-robin runs over ports 1..PORTS-1, and the pointer advances only over those ports.
  - Packets are still atomic; port 0 never preempts a packet in progress.
- Undefined: pure round-robin over all PORTS as described above.

Test Plan:
- Reset: assert rst mid-packet while port 1 is in XFER → grant = 0, busy = 0, out_valid = 0 and in_ready = 0 immediately; after release the pointer is 0.
- Single request: port 1 sends a 3-beat TLP (hdr = 0x0000_000A_..., sop on beat 0, eop on beat 2), out_ready = 1 → out_valid rises 1 cycle after in_valid; 3 beats appear in order; grant = 2'b10; IDLE after the eop beat.
- Contention: ports 0 and 1 continuously valid with 2-beat packets, PORTS = 2 → grant sequence 01, 10, 01, 10 with one idle cycle between packets; no interleaving.
- Backpressure: out_ready toggles 1, 0, 0, 1 during a 4-beat packet → in_ready[g] mirrors out_ready; beats are neither duplicated nor dropped; the other port's in_ready stays 0.
- Enable and errors:
  - enable = 0 with requests pending → grant stays 0.
  - enable dropped mid-packet → the packet finishes and no further grant is issued.
  - A first beat without sop → sop_err pulses once.
- TLP_ARB_PRIO0_EN: ports 0 and 1 both always valid → every arbitration picks port 0; port 1 is granted only in a cycle where in_valid[0] = 0.
